// File: rtl/dmem_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : dmem_arb_pkg
// Brief   : Shared types and default widths for the data-memory port arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_arb_pkg;

  localparam int c_addr_w_default     = 32;
  localparam int c_data_w_default     = 32;
  localparam int c_starve_max_default = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    P_BUSY = 2'd1,
    S_BUSY = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arb_req_latch.sv
//------------------------------------------------------------------------------
// Module  : dmem_arb_req_latch
// Brief   : Grant-time capture of we/addr/wdata from the selected requester.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arb_req_latch
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = c_addr_w_default,
  parameter int DATA_W = c_data_w_default
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,
  input  logic              sel,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  // sel=1 picks the secondary requester
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (load) begin
      r_we    <= sel ? s_we    : p_we;
      r_addr  <= sel ? s_addr  : p_addr;
      r_wdata <= sel ? s_wdata : p_wdata;
    end
  end

  assign we    = r_we;
  assign addr  = r_addr;
  assign wdata = r_wdata;

endmodule

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
//------------------------------------------------------------------------------
// Module  : dmem_port_arbiter
// Brief   : Shares the data-memory port between the MEM stage and a secondary
//           requester; optional fairness enabled by DMEM_ARB_FAIR_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = c_addr_w_default,
  parameter int DATA_W     = c_data_w_default,
  parameter int STARVE_MAX = c_starve_max_default
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_freeze,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_gnt,
  output logic              s_done,
  output logic [DATA_W-1:0] s_rdata,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_W-1:0] m_rdata
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_grant_p;
  logic              w_grant_s;
  logic              w_force_s;
  logic              w_s_ack;
  logic              r_m_req;
  logic              r_s_gnt;
  logic              r_s_done;
  logic [DATA_W-1:0] r_s_rdata;

`ifdef DMEM_ARB_FAIR_EN
  localparam int                 c_cnt_w      = $clog2(STARVE_MAX + 1);
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

  logic [c_cnt_w-1:0] r_starve;

  // Counts primary wins over a waiting secondary; saturates at the limit
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_starve <= '0;
    end else if (w_grant_s) begin
      r_starve <= '0;
    end else if (w_grant_p && s_req && (r_starve != c_starve_max)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign w_force_s = s_req && (r_starve == c_starve_max);
`else
  wire w_unused_starve = (STARVE_MAX > 0);
  assign w_force_s = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant_p   = 1'b0;
    w_grant_s   = 1'b0;
    case (r_state)
      IDLE: begin
        if (p_req && !w_force_s) begin
          w_state_nxt = P_BUSY;
          w_grant_p   = 1'b1;
        end else if (s_req) begin
          w_state_nxt = S_BUSY;
          w_grant_s   = 1'b1;
        end
      end
      P_BUSY: if (m_ack) w_state_nxt = IDLE;
      S_BUSY: if (m_ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_s_ack = (r_state == S_BUSY) && m_ack;

  // Every grant leaves via IDLE, so m_req always drops for a bubble cycle
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_m_req   <= 1'b0;
      r_s_gnt   <= 1'b0;
      r_s_done  <= 1'b0;
      r_s_rdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_m_req  <= (w_state_nxt != IDLE);
      r_s_gnt  <= w_grant_s;
      r_s_done <= w_s_ack;
      if (w_s_ack) begin
        r_s_rdata <= m_rdata;
      end
    end
  end

  dmem_arb_req_latch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_latch (
    .CLK     (CLK),
    .RESET   (RESET),
    .load    (w_grant_p | w_grant_s),
    .sel     (w_grant_s),
    .p_we    (p_we),
    .p_addr  (p_addr),
    .p_wdata (p_wdata),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .we      (m_we),
    .addr    (m_addr),
    .wdata   (m_wdata)
  );

  // Freeze drops in the primary ack cycle so MEM/WB captures p_rdata
  assign p_freeze = !RESET && p_req && !((r_state == P_BUSY) && m_ack);
  assign p_rdata  = m_rdata;
  assign m_req    = r_m_req;
  assign s_gnt    = r_s_gnt;
  assign s_done   = r_s_done;
  assign s_rdata  = r_s_rdata;

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (primary) and a secondary requester such as a debug or DMA engine (secondary).
- Sequences multi-cycle memory transactions with a req/ack handshake.
- Drives the pipeline FREEZE while a primary access is outstanding.
- Sits between the MEM stage memory outputs (MemRead/MemWrite/address/write data) and the data memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive primary grants before the secondary is forced a grant. Used only with DMEM_ARB_FAIR_EN.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset.
- p_req  in  1  primary request (MemRead or MemWrite). Held stable until released.
- p_we  in  1  primary write enable (1=store, 0=load).
- p_addr  in  ADDR_W  primary address.
- p_wdata  in  DATA_W  primary store data.
- p_rdata  out  DATA_W  primary load data, valid in the ack cycle.
- p_freeze  out  1  pipeline FREEZE.
- s_req  in  1  secondary request. Held until s_done.
- s_we  in  1  secondary write enable.
- s_addr  in  ADDR_W  secondary address.
- s_wdata  in  DATA_W  secondary store data.
- s_gnt  out  1  one-cycle pulse: secondary request accepted.
- s_done  out  1  one-cycle pulse: secondary transaction complete.
- s_rdata  out  DATA_W  secondary load data, registered, held until the next s_done.
- m_req  out  1  memory request, registered.
- m_we  out  1  memory write enable, registered.
- m_addr  out  ADDR_W  memory address, registered.
- m_wdata  out  DATA_W  memory write data, registered.
- m_ack  in  1  memory completion, one-cycle pulse.
- m_rdata  in  DATA_W  memory read data, valid when m_ack=1.

Behaviour:
- Reset: RESET is asynchronous and active-high; clock is CLK.
  - Reset values: state=IDLE; m_req, m_we, s_gnt, s_done = 0; m_addr, m_wdata, s_rdata = 0; starve counter = 0.
  - p_freeze is forced 0 while RESET=1.
  - An outstanding memory transaction is abandoned on reset; the memory must tolerate m_req dropping.
- FSM states: IDLE, P_BUSY, S_BUSY.
- IDLE arbitration:
  - p_req=1: go to P_BUSY. Register m_req=1 and m_we/m_addr/m_wdata from the p_* inputs.
  - Else s_req=1: go to S_BUSY. Latch from the s_* inputs and pulse s_gnt.
  - Simultaneous requests: primary wins, unless the fairness rule applies.
- P_BUSY:
  - Hold all m_* signals stable until m_ack.
  - On m_ack: clear m_req at the next edge and return to IDLE.
- S_BUSY:
  - On m_ack: register s_rdata<=m_rdata, pulse s_done in the following cycle, clear m_req and return to IDLE.
- Returning to IDLE:
  - There is no direct BUSY->BUSY transition; a new grant always passes through IDLE (one bubble cycle).
  - m_req is therefore low for at least one cycle between transactions.
- p_freeze (combinational) = p_req AND NOT (state==P_BUSY AND m_ack).
  - The primary is frozen while the secondary owns the port.
  - The primary is frozen in IDLE before grant.
- p_rdata = m_rdata (pass-through). The MEM/WB register captures it in the ack cycle because freeze drops then.
- Minimum primary latency: p_req in cycle N, m_req high in N+1. A zero-wait memory acks in N+1, so freeze covers exactly cycle N.
- A stale p_req in the ack cycle belongs to the completing instruction. Next cycle, IDLE treats p_req as a new instruction.
- m_ack is ignored in IDLE.
- Primary flush mid-transaction is not supported; p_req must not drop before release.
- Stores: m_wdata is latched at grant. Store data forwarding is resolved upstream, before p_wdata.

Optional Feature:
- Macro DMEM_ARB_FAIR_EN.
- Defined: a saturating starve counter increments on each primary grant made while s_req=1, and clears on any secondary grant.
  - When the counter reaches STARVE_MAX, the next IDLE arbitration grants the secondary even if p_req=1.
- Undefined: strict primary priority; the secondary may starve indefinitely. No counter logic is present.

Decomposition:
- Package dmem_arb_pkg:
  - state enum (IDLE/P_BUSY/S_BUSY);
  - default widths;
  - STARVE_MAX default.
- One natural sub-module: dmem_arb_req_latch, the grant-time capture register for we/addr/wdata with a select input.
- FSM and freeze logic stay in the top.

Test Plan:
- Primary load, zero-wait memory: p_req=1, p_we=0, p_addr=0x100, m_ack in the cycle after grant returning 0xDEADBEEF -> p_freeze high exactly 1 cycle; p_rdata=0xDEADBEEF in the ack cycle; m_addr=0x100.
- Secondary store, 3-wait memory: s_req=1, s_addr=0x40, s_wdata=0x12345678, m_ack 3 cycles after m_req -> s_gnt pulse; m_* stable 3 cycles; s_done 1 cycle after ack; p_freeze 0 when p_req=0.
- Simultaneous p_req and s_req, strict mode -> primary granted first. Secondary granted in the IDLE after the primary ack. p_freeze held while S_BUSY if a new p_req arrives.
- DMEM_ARB_FAIR_EN with STARVE_MAX=4: p_req continuously high (back-to-back loads) and s_req high -> exactly 4 primary grants, then a secondary grant; the counter resets.
- RESET asserted while P_BUSY with m_req=1 -> m_req, s_gnt, s_done go to 0 asynchronously; p_freeze=0; state=IDLE. After release, a fresh p_req is granted normally.
- m_ack pulse while IDLE -> no state change, no s_done, m_req stays 0.
